// File: rtl/mem_access_pkg.sv
// Shared encodings for the port-A request front-end: size codes, FSM states, lane geometry.
package mem_access_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store write-enables and replicated data, load extraction, alignment check.
// Purely combinational; no latency, no backpressure.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]              size,
    input  logic [1:0]              addr_lo,
    input  logic [LANES*LANE_W-1:0] wdata,
    input  logic [LANES*LANE_W-1:0] rdata_raw,
    input  logic                    sign_ext,
    output logic [LANES-1:0]        we,
    output logic [LANES*LANE_W-1:0] din,
    output logic [LANES*LANE_W-1:0] rdata,
    output logic                    misalign
);

    logic [LANE_W-1:0]   byte_sel;
    logic [2*LANE_W-1:0] half_sel;

    assign byte_sel = rdata_raw[{addr_lo, 3'b000} +: LANE_W];
    assign half_sel = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];

    always_comb begin
        we       = '0;
        din      = wdata;
        rdata    = '0;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                din   = {LANES{wdata[7:0]}};
                we    = 4'b0001 << addr_lo;
                rdata = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                din      = {2{wdata[15:0]}};
                we       = addr_lo[1] ? 4'b1100 : 4'b0011;
                rdata    = {{16{sign_ext & half_sel[15]}}, half_sel};
                misalign = addr_lo[0];
            end
            SZ_WORD: begin
                din      = wdata;
                we       = 4'b1111;
                rdata    = rdata_raw;
                misalign = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Port-A load/store front-end; latency store 2, load 3, error 1 cycle; one request in flight.
// req_ready only in IDLE, response held until rsp_ready. MEMCTRL_SIGNEXT_EN enables signed loads.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clkA,
    input  logic                  rstA,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  enaA,
    output logic [LANES-1:0]      weA,
    output logic [ADDR_WIDTH-1:0] addrA,
    output logic [DATA_WIDTH-1:0] dinA,
    input  logic [DATA_WIDTH-1:0] doutA
);

    generate
        if (DATA_WIDTH != LANES * LANE_W) begin : g_bad_width
            $error("mem_access_ctrl: DATA_WIDTH must be 32");
        end
    endgenerate

    state_e                state_q, state_d;
    logic [1:0]            size_q;
    logic [1:0]            lo_q;
    logic                  store_q;
    logic                  sign_ext;
    logic [1:0]            al_size;
    logic [1:0]            al_lo;
    logic [LANES-1:0]      al_we;
    logic [DATA_WIDTH-1:0] al_din;
    logic [DATA_WIDTH-1:0] al_rdata;
    logic                  al_misalign;
    logic                  accept;
    logic                  illegal;

    // The aligner sees the live request while idle and the captured one afterwards.
    assign al_size   = (state_q == ST_IDLE) ? req_size     : size_q;
    assign al_lo     = (state_q == ST_IDLE) ? req_addr[1:0] : lo_q;
    assign req_ready = (state_q == ST_IDLE) && !rstA;
    assign rsp_valid = (state_q == ST_RESP);
    assign accept    = req_valid && req_ready;
    assign illegal   = (req_size == SZ_RSVD) || al_misalign;

`ifdef MEMCTRL_SIGNEXT_EN
    logic unsigned_q;
    always_ff @(posedge clkA) begin
        if (rstA)        unsigned_q <= 1'b0;
        else if (accept) unsigned_q <= req_unsigned;
    end
    assign sign_ext = !unsigned_q;
`else
    logic unused_unsigned;
    assign unused_unsigned = req_unsigned;
    assign sign_ext        = 1'b0;
`endif

    mem_lane_align u_align (
        .size      (al_size),
        .addr_lo   (al_lo),
        .wdata     (req_wdata),
        .rdata_raw (doutA),
        .sign_ext  (sign_ext),
        .we        (al_we),
        .din       (al_din),
        .rdata     (al_rdata),
        .misalign  (al_misalign)
    );

    always_ff @(posedge clkA) begin
        if (rstA) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = illegal ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_d = store_q ? ST_RESP : ST_WAIT;
            ST_WAIT:  state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkA) begin
        if (rstA) begin
            enaA      <= 1'b0;
            weA       <= '0;
            addrA     <= '0;
            dinA      <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            size_q    <= SZ_BYTE;
            lo_q      <= '0;
            store_q   <= 1'b0;
        end else begin
            // Enable and write strobes are one-cycle pulses; address and data persist.
            enaA <= 1'b0;
            weA  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        size_q    <= req_size;
                        lo_q      <= req_addr[1:0];
                        store_q   <= req_we;
                        rsp_err   <= illegal;
                        rsp_rdata <= '0;
                        if (!illegal) begin
                            enaA  <= 1'b1;
                            addrA <= req_addr[ADDR_WIDTH+1:2];
                            if (req_we) begin
                                weA  <= al_we;
                                dinA <= al_din;
                            end
                        end
                    end
                end
                ST_WAIT: rsp_rdata <= al_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-write RAM model on port A, byte-array reference memory.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

`ifdef MEMCTRL_SIGNEXT_EN
    localparam bit SIGNEXT = 1'b1;
`else
    localparam bit SIGNEXT = 1'b0;
`endif

    logic        clkA = 1'b0;
    logic        rstA;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        enaA;
    logic [3:0]  weA;
    logic [5:0]  addrA;
    logic [31:0] dinA, doutA;

    int n_pass = 0;
    int n_total = 0;

    logic        ram_clr;
    logic [31:0] ram [64];
    logic [7:0]  ref_mem [256];

    always #5 clkA = ~clkA;

    mem_access_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .clkA(clkA), .rstA(rstA),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .enaA(enaA), .weA(weA),
        .addrA(addrA), .dinA(dinA), .doutA(doutA)
    );

    always @(posedge clkA) begin
        if (ram_clr) begin
            for (int k = 0; k < 64; k++) ram[k] <= '0;
            doutA <= '0;
        end else if (enaA) begin
            if (weA == 4'b0000) doutA <= ram[addrA];
            else for (int k = 0; k < 4; k++)
                if (weA[k]) ram[addrA][k*8 +: 8] <= dinA[k*8 +: 8];
        end
    end

    function automatic bit ref_legal(input logic [1:0] size, input logic [7:0] a);
        return (size == 2'd0) || (size == 2'd1 && !a[0]) || (size == 2'd2 && a[1:0] == 2'd0);
    endfunction

    function automatic logic [3:0] ref_mask(input logic [1:0] size, input logic [7:0] a);
        int nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        logic [3:0] m = '0;
        for (int i = 0; i < nbytes; i++) m[(a[1:0] + i) % 4] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [7:0] a, input logic uns);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = {24'd0, ref_mem[a]};
            if (SIGNEXT && !uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = {16'd0, ref_mem[a | 8'd1], ref_mem[a]};
            if (SIGNEXT && !uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = {ref_mem[{a[7:2], 2'd3}], ref_mem[{a[7:2], 2'd2}],
                 ref_mem[{a[7:2], 2'd1}], ref_mem[{a[7:2], 2'd0}]};
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [7:0] a, input logic [31:0] d);
        int nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int i = 0; i < nbytes; i++) ref_mem[a + 8'(i)] = d[i*8 +: 8];
    endtask

    // Drives one request and reports what was observed; the stall phase offers a stray request.
    task automatic issue_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [7:0] a, input logic [31:0] d, input int hold,
                             output int lat, output int ena_cnt, output logic [3:0] we_seen,
                             output logic [5:0] addr_seen, output logic err,
                             output logic [31:0] rdata, output logic stall_ok);
        int guard = 0;
        lat = -1; ena_cnt = 0; we_seen = '0; addr_seen = '0; err = 1'b0; rdata = '0; stall_ok = 1'b1;
        while (!req_ready && guard < 50) begin @(posedge clkA); #1; guard++; end
        if (!req_ready) return;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = a; req_wdata = d;
        @(posedge clkA); #1;
        req_valid = 1'b0; req_wdata = $urandom;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            if (enaA) begin ena_cnt++; we_seen = weA; addr_seen = addrA; end
            @(posedge clkA); #1; lat++;
        end
        if (enaA) ena_cnt++;
        if (!rsp_valid) begin lat = -1; return; end
        err = rsp_err; rdata = rsp_rdata;
        for (int k = 0; k < hold; k++) begin
            req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_addr = 8'h00;
            req_wdata = 32'hDEAD_BEEF;
            @(posedge clkA); #1;
            if (!rsp_valid || rsp_err !== err || rsp_rdata !== rdata || req_ready || enaA)
                stall_ok = 1'b0;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clkA); #1;
        rsp_ready = 1'b0;
        if (rsp_valid || enaA) stall_ok = 1'b0;
    endtask

    task automatic test_reset;
        rstA = 1'b1; ram_clr = 1'b1;
        repeat (3) @(posedge clkA);
        #1;
        n_total++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, enaA, weA, addrA, dinA} !== '0)
            $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rdata=%h ena=%b we=%b addr=%h din=%h, need all 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata, enaA, weA, addrA, dinA);
        else n_pass++;
        rstA = 1'b0; ram_clr = 1'b0;
        @(posedge clkA); #1;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b need 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_word_store_load;
        int lat, ena; logic [3:0] w; logic [5:0] ad; logic e, ok; logic [31:0] rd;
        issue_req(1'b1, SZ_WORD, 1'b0, 8'h00, 32'h1234_5678, 0, lat, ena, w, ad, e, rd, ok);
        ref_store(SZ_WORD, 8'h00, 32'h1234_5678);
        n_total++;
        if (lat !== 1 || ena !== 1 || w !== 4'b1111 || e !== 1'b0 || rd !== 32'h0)
            $display("FAIL word_store: got lat=%0d ena=%0d we=%b err=%b rdata=%h need 1 1 1111 0 0", lat, ena, w, e, rd);
        else n_pass++;
        issue_req(1'b0, SZ_WORD, 1'b0, 8'h00, 32'h0, 0, lat, ena, w, ad, e, rd, ok);
        n_total++;
        if (lat !== 2 || ena !== 1 || w !== 4'b0000 || rd !== ref_load(SZ_WORD, 8'h00, 1'b0))
            $display("FAIL word_load: got lat=%0d ena=%0d we=%b rdata=%h need 2 1 0000 %h",
                     lat, ena, w, rd, ref_load(SZ_WORD, 8'h00, 1'b0));
        else n_pass++;
    endtask

    task automatic test_byte_lanes;
        int lat, ena; logic [3:0] w; logic [5:0] ad; logic e, ok; logic [31:0] rd;
        for (int a = 1; a < 4; a++) begin
            issue_req(1'b1, SZ_BYTE, 1'b0, 8'(a), 32'h0000_00AA, 0, lat, ena, w, ad, e, rd, ok);
            ref_store(SZ_BYTE, 8'(a), 32'h0000_00AA);
            n_total++;
            if (w !== ref_mask(SZ_BYTE, 8'(a)) || lat !== 1 || ad !== 6'd0)
                $display("FAIL byte_store_lane%0d: got we=%b lat=%0d addr=%h need %b 1 0", a, w, lat, ad,
                         ref_mask(SZ_BYTE, 8'(a)));
            else n_pass++;
        end
        issue_req(1'b0, SZ_WORD, 1'b0, 8'h00, 32'h0, 0, lat, ena, w, ad, e, rd, ok);
        n_total++;
        if (rd !== 32'hAAAA_AA78) $display("FAIL byte_merge_load: got %h need aaaaaa78", rd);
        else n_pass++;
    endtask

    task automatic test_half_sign;
        int lat, ena; logic [3:0] w; logic [5:0] ad; logic e, ok; logic [31:0] rd;
        logic [31:0] need;
        issue_req(1'b1, SZ_WORD, 1'b0, 8'h00, 32'h8001_1234, 0, lat, ena, w, ad, e, rd, ok);
        ref_store(SZ_WORD, 8'h00, 32'h8001_1234);
        need = SIGNEXT ? 32'hFFFF_8001 : 32'h0000_8001;
        issue_req(1'b0, SZ_HALF, 1'b0, 8'h02, 32'h0, 0, lat, ena, w, ad, e, rd, ok);
        n_total++;
        if (rd !== need || lat !== 2) $display("FAIL half_load_signed: got %h lat=%0d need %h 2", rd, lat, need);
        else n_pass++;
        issue_req(1'b0, SZ_HALF, 1'b1, 8'h02, 32'h0, 0, lat, ena, w, ad, e, rd, ok);
        n_total++;
        if (rd !== 32'h0000_8001) $display("FAIL half_load_unsigned: got %h need 00008001", rd);
        else n_pass++;
    endtask

    task automatic test_misaligned;
        int lat, ena; logic [3:0] w; logic [5:0] ad; logic e, ok; logic [31:0] rd;
        logic [1:0] sz [3] = '{SZ_WORD, SZ_HALF, SZ_RSVD};
        logic [7:0] ax [3] = '{8'h06, 8'h03, 8'h00};
        logic       wx [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            issue_req(wx[i], sz[i], 1'b0, ax[i], 32'hFFFF_FFFF, 0, lat, ena, w, ad, e, rd, ok);
            n_total++;
            if (lat !== 0 || ena !== 0 || e !== 1'b1 || rd !== 32'h0)
                $display("FAIL illegal_req%0d: got lat=%0d ena=%0d err=%b rdata=%h need 0 0 1 0", i, lat, ena, e, rd);
            else n_pass++;
        end
        issue_req(1'b0, SZ_WORD, 1'b0, 8'h00, 32'h0, 0, lat, ena, w, ad, e, rd, ok);
        n_total++;
        if (rd !== ref_load(SZ_WORD, 8'h00, 1'b0))
            $display("FAIL illegal_no_write: got %h need %h", rd, ref_load(SZ_WORD, 8'h00, 1'b0));
        else n_pass++;
    endtask

    task automatic test_stall;
        int lat, ena; logic [3:0] w; logic [5:0] ad; logic e, ok; logic [31:0] rd;
        issue_req(1'b0, SZ_WORD, 1'b0, 8'h00, 32'h0, 5, lat, ena, w, ad, e, rd, ok);
        n_total++;
        if (ok !== 1'b1 || rd !== ref_load(SZ_WORD, 8'h00, 1'b0) || lat !== 2)
            $display("FAIL stall_hold: got stable=%b rdata=%h lat=%0d need 1 %h 2", ok, rd, lat,
                     ref_load(SZ_WORD, 8'h00, 1'b0));
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int guard = 0;
        bit seen = 1'b0;
        while (!req_ready && guard < 50) begin @(posedge clkA); #1; guard++; end
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_addr = 8'h00;
        @(posedge clkA); #1;
        req_valid = 1'b0;
        @(posedge clkA); #1;
        rstA = 1'b1;
        @(posedge clkA); #1;
        n_total++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, enaA, weA, addrA, dinA} !== '0)
            $display("FAIL reset_mid_outputs: got rdy=%b vld=%b err=%b rdata=%h ena=%b we=%b addr=%h din=%h, need all 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata, enaA, weA, addrA, dinA);
        else n_pass++;
        rstA = 1'b0;
        @(posedge clkA); #1;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL reset_mid_ready: got %b need 1", req_ready);
        else n_pass++;
        repeat (4) begin
            if (rsp_valid) seen = 1'b1;
            @(posedge clkA); #1;
        end
        n_total++;
        if (seen) $display("FAIL reset_mid_no_rsp: got rsp_valid=1 need 0");
        else n_pass++;
    endtask

    task automatic test_random;
        int lat, ena; logic [3:0] w; logic [5:0] ad; logic e, ok; logic [31:0] rd;
        logic we, uns; logic [1:0] size; logic [7:0] a; logic [31:0] d;
        bit legal; int need_lat; logic [31:0] need_rd;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3)); a = 8'($urandom_range(0, 31)); d = $urandom;
            legal = ref_legal(size, a);
            need_lat = !legal ? 0 : (we ? 1 : 2);
            need_rd = (!legal || we) ? 32'h0 : ref_load(size, a, uns);
            issue_req(we, size, uns, a, d, 0, lat, ena, w, ad, e, rd, ok);
            n_total++;
            if (lat !== need_lat || e !== !legal || rd !== need_rd || ena !== (legal ? 1 : 0) ||
                (legal && we && (w !== ref_mask(size, a) || ad !== a[7:2])))
                $display("FAIL random%0d we=%b sz=%0d a=%h: got lat=%0d err=%b rdata=%h ena=%0d we=%b addr=%h need lat=%0d err=%b rdata=%h",
                         n, we, size, a, lat, e, rd, ena, w, ad, need_lat, !legal, need_rd);
            else n_pass++;
            if (legal && we) ref_store(size, a, d);
        end
    endtask

    task automatic test_mem_final;
        logic [31:0] need;
        int bad = 0;
        for (int wd = 0; wd < 64; wd++) begin
            need = {ref_mem[wd*4+3], ref_mem[wd*4+2], ref_mem[wd*4+1], ref_mem[wd*4]};
            if (ram[wd] !== need) begin
                bad++;
                $display("FAIL mem_word%0d: got %h need %h", wd, ram[wd], need);
            end
        end
        n_total++;
        if (bad == 0) n_pass++;
    endtask

    initial begin
        rstA = 1'b1; ram_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = SZ_BYTE; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_word_store_load();
        test_byte_lanes();
        test_half_sign();
        test_misaligned();
        test_stall();
        test_reset_mid();
        test_random();
        test_mem_final();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
